// File: rtl/nand_bus_ctrl.sv
// nand_bus_ctrl: CPU-side NAND flash bus controller.
// Turns single register accesses into timed command, address, data-write and
// data-read cycles on the NAND pins. One cycle engine serialises all bus cycles.
// Firmware polls STATUS.BUSY; a launch while busy is dropped and sets the
// sticky STATUS.OVR flag.
//
// Optional feature macro: NAND_PREFETCH_EN
//   defined   : a DATA read returns rdata and, when idle, launches the next
//               read cycle (when busy it sets OVR instead).
//   undefined : DATA read only returns rdata; reads launch via STATUS bit2.
//
// Register map: 0 CMD (w), 1 ADDR (w), 2 DATA (r/w), 3 STATUS (r/w)
// STATUS read : {4'b0, OVR, 1'b0, CE, BUSY}
// STATUS write: bit1 -> CE, bit2 = 1 launches a read cycle, bit3 = 1 clears OVR
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no bus cycle, pins idle, BUSY = 0
// S_SETUP  | control/data set up ahead of the strobe (T_SETUP clocks)
// S_STROBE | nwe or nre held low (T_PULSE clocks), read sampled at end
// S_HOLD   | strobe released, control/data held (T_HOLD clocks)
module nand_bus_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 3,
  parameter int T_HOLD  = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_cs,
  input  logic       i_we,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_nand_oe,
  output logic [7:0] o_nand_dout,
  input  logic [7:0] i_nand_din,
  output logic       o_nce,
  output logic       o_ncle,
  output logic       o_nale,
  output logic       o_nwe,
  output logic       o_nre
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;
  typedef enum logic [1:0] {K_CMD, K_ADDR, K_WR, K_RD} kind_t;

  localparam logic [3:0] C_SETUP = 4'(T_SETUP - 1);
  localparam logic [3:0] C_PULSE = 4'(T_PULSE - 1);
  localparam logic [3:0] C_HOLD  = 4'(T_HOLD - 1);

  localparam logic [1:0] A_CMD    = 2'd0;
  localparam logic [1:0] A_ADDR   = 2'd1;
  localparam logic [1:0] A_DATA   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  state_t     r_state;
  kind_t      r_kind;
  logic [3:0] r_cnt;
  logic       r_ncle;
  logic       r_nale;
  logic       r_nwe;
  logic       r_nre;
  logic       r_oe;
  logic [7:0] r_nand_dout;
  logic [7:0] r_rdata;
  logic [7:0] r_dout;
  logic       r_ce;
  logic       r_ovr;

  state_t     w_state_nx;
  kind_t      w_kind_nx;
  kind_t      w_kind;
  logic [3:0] w_cnt_nx;
  logic       w_launch;
  logic       w_start;
  logic       w_ovr_set;
  logic       w_ovr_clr;
  logic       w_busy;
  logic       w_wr;
  logic       w_rd;
  logic       w_sample;
  logic       w_active_nx;
  logic       w_strobe_nx;
  logic       w_ncle_nx;
  logic       w_nale_nx;
  logic       w_nwe_nx;
  logic       w_nre_nx;
  logic       w_oe_nx;
  logic [7:0] w_status;
  logic [7:0] w_rd_mux;
  logic       w_unused_din;

  assign w_wr     = i_cs & i_we;
  assign w_rd     = i_cs & ~i_we;
  assign w_busy   = (r_state != S_IDLE);
  assign w_status = {4'b0000, r_ovr, 1'b0, r_ce, w_busy};
  assign w_sample = (r_state == S_STROBE) && (r_cnt == 4'd0);
  assign w_unused_din = &{1'b0, i_din[7:4], i_din[0]};

  // Decode register accesses into a launch request and its cycle kind.
  always_comb begin
    w_launch = 1'b0;
    w_kind   = K_CMD;
    if (w_wr) begin
      case (i_addr)
        A_CMD:    begin w_launch = 1'b1; w_kind = K_CMD;  end
        A_ADDR:   begin w_launch = 1'b1; w_kind = K_ADDR; end
        A_DATA:   begin w_launch = 1'b1; w_kind = K_WR;   end
        default:  begin w_launch = i_din[2]; w_kind = K_RD; end
      endcase
    end
`ifdef NAND_PREFETCH_EN
    if (w_rd && (i_addr == A_DATA)) begin
      w_launch = 1'b1;
      w_kind   = K_RD;
    end
`else
    // DATA reads never launch a cycle in this build.
`endif
    w_start   = w_launch & ~w_busy;
    w_ovr_set = w_launch & w_busy;
    w_ovr_clr = w_wr && (i_addr == A_STATUS) && i_din[3];
  end

  // Next-state, phase counter and next pin values for the cycle engine.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt - 4'd1;
    w_kind_nx  = r_kind;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = 4'd0;
        if (w_start) begin
          w_state_nx = S_SETUP;
          w_cnt_nx   = C_SETUP;
          w_kind_nx  = w_kind;
        end
      end
      S_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nx = S_STROBE;
          w_cnt_nx   = C_PULSE;
        end
      end
      S_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_nx = S_HOLD;
          w_cnt_nx   = C_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = 4'd0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = 4'd0;
      end
    endcase
    // Pins are registered from the next state so they switch glitch-free
    // on the same edge the state does.
    w_active_nx = (w_state_nx != S_IDLE);
    w_strobe_nx = (w_state_nx == S_STROBE);
    w_ncle_nx   = w_active_nx && (w_kind_nx == K_CMD);
    w_nale_nx   = w_active_nx && (w_kind_nx == K_ADDR);
    w_oe_nx     = w_active_nx && (w_kind_nx != K_RD);
    w_nwe_nx    = !(w_strobe_nx && (w_kind_nx != K_RD));
    w_nre_nx    = !(w_strobe_nx && (w_kind_nx == K_RD));
  end

  // CPU read data mux.
  always_comb begin
    case (i_addr)
      A_DATA:   w_rd_mux = r_rdata;
      A_STATUS: w_rd_mux = w_status;
      default:  w_rd_mux = 8'h00;
    endcase
  end

  // Cycle engine state register and registered NAND control pins.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_kind  <= K_CMD;
      r_cnt   <= 4'd0;
      r_ncle  <= 1'b0;
      r_nale  <= 1'b0;
      r_nwe   <= 1'b1;
      r_nre   <= 1'b1;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_kind  <= w_kind_nx;
      r_cnt   <= w_cnt_nx;
      r_ncle  <= w_ncle_nx;
      r_nale  <= w_nale_nx;
      r_nwe   <= w_nwe_nx;
      r_nre   <= w_nre_nx;
      r_oe    <= w_oe_nx;
    end
  end

  // Register file: write byte latch, read sample, CE, OVR and CPU read data.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_nand_dout <= 8'h00;
      r_rdata     <= 8'h00;
      r_dout      <= 8'h00;
      r_ce        <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      if (w_start && (w_kind != K_RD)) r_nand_dout <= i_din;
      if (w_sample) r_rdata <= i_nand_din;
      if (w_wr && (i_addr == A_STATUS)) r_ce <= i_din[1];
      if (w_ovr_set) r_ovr <= 1'b1;
      else if (w_ovr_clr) r_ovr <= 1'b0;
      if (w_rd) r_dout <= w_rd_mux;
    end
  end

  assign o_dout      = r_dout;
  assign o_nand_oe   = r_oe;
  assign o_nand_dout = r_nand_dout;
  assign o_nce       = ~r_ce;
  assign o_ncle      = r_ncle;
  assign o_nale      = r_nale;
  assign o_nwe       = r_nwe;
  assign o_nre       = r_nre;

endmodule
